// File: rtl/rgb_button_ctrl.sv
// Colour push-button controller: sync, debounce, arbitrate and auto-repeat three
// active-low buttons into 8-bit R/G/B channel values.
module rgb_button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000,
  parameter int unsigned STEP            = 8,
  parameter bit          WRAP            = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn_n,
  input  logic       dec,
  output logic [7:0] R_value,
  output logic [7:0] G_value,
  output logic [7:0] B_value,
  output logic [1:0] sel,
  output logic       upd
);

  localparam int unsigned DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);
  localparam logic [8:0]    STEP9       = 9'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      deb_q, deb_d;
  logic [DW-1:0]   cnt_q [3];
  logic [DW-1:0]   cnt_d [3];
  logic [2:0]      armed_q, armed_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      r_q, r_d;
  logic [7:0]      g_q, g_d;
  logic [7:0]      b_q, b_d;
  logic [1:0]      sel_q, sel_d;
  logic            upd_q, upd_d;

  logic [2:0]      pressed;
  logic [2:0]      eligible;
  logic [1:0]      pick;
  logic            held;
  logic            step_en;
  logic [1:0]      step_ch;

  // One step of channel arithmetic with a 9-bit intermediate to catch carry/borrow.
  function automatic logic [7:0] step_value(input logic [7:0] v, input logic down);
    logic [8:0] s;
    logic [7:0] res;
    if (down) begin
      s   = {1'b0, v} - STEP9;
      res = (!WRAP && s[8]) ? 8'h00 : s[7:0];
    end else begin
      s   = {1'b0, v} + STEP9;
      res = (!WRAP && s[8]) ? 8'hFF : s[7:0];
    end
    return res;
  endfunction

  // Two-flop synchroniser followed by a per-button stability counter.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign pressed  = ~deb_q;
  assign eligible = pressed & armed_q;
  assign pick     = eligible[2] ? 2'b01 : (eligible[1] ? 2'b10 : 2'b11);

  always_comb begin
    held = 1'b0;
    case (sel_q)
      2'b01:   held = pressed[2];
      2'b10:   held = pressed[1];
      2'b11:   held = pressed[0];
      default: held = 1'b0;
    endcase
  end

  // Presses seen while a channel is held (or losing arbitration) stay disarmed until released.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    upd_d   = 1'b0;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    armed_d = armed_q | deb_q;
    step_en = 1'b0;
    step_ch = sel_q;

    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          step_en = 1'b1;
          step_ch = pick;
          sel_d   = pick;
          armed_d = armed_d & ~pressed;
          timer_d = DELAY_LOAD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        armed_d = armed_d & ~pressed;
        if (!held) begin
          sel_d   = 2'b00;
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          step_en = 1'b1;
          timer_d = PERIOD_LOAD;
          state_d = ST_REPEAT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        sel_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase

    if (step_en) begin
      upd_d = 1'b1;
      case (step_ch)
        2'b01:   r_d = step_value(r_q, dec);
        2'b10:   g_d = step_value(g_q, dec);
        2'b11:   b_d = step_value(b_q, dec);
        default: upd_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      deb_q   <= 3'b111;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      armed_q <= 3'b111;
      timer_q <= '0;
      r_q     <= 8'h00;
      g_q     <= 8'h00;
      b_q     <= 8'h00;
      sel_q   <= 2'b00;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      armed_q <= armed_d;
      timer_q <= timer_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      upd_q   <= upd_d;
    end
  end

  assign R_value = r_q;
  assign G_value = g_q;
  assign B_value = b_q;
  assign sel     = sel_q;
  assign upd     = upd_q;

endmodule

// File: tb/tb_rgb_button_ctrl.sv
// Directed bench for rgb_button_ctrl: one wrapping and one saturating instance share stimulus.
module tb_rgb_button_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] btn_n;
  logic       dec;

  logic [7:0] r_w, g_w, b_w, r_s, g_s, b_s;
  logic [1:0] sel_w, sel_s;
  logic       upd_w, upd_s;

  int checks = 0;
  int errors = 0;

  rgb_button_ctrl #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .STEP(8), .WRAP(1'b1)
  ) dut_w (
    .clk(clk), .reset(reset), .btn_n(btn_n), .dec(dec),
    .R_value(r_w), .G_value(g_w), .B_value(b_w), .sel(sel_w), .upd(upd_w)
  );

  rgb_button_ctrl #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .STEP(8), .WRAP(1'b0)
  ) dut_s (
    .clk(clk), .reset(reset), .btn_n(btn_n), .dec(dec),
    .R_value(r_s), .G_value(g_s), .B_value(b_s), .sel(sel_s), .upd(upd_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int nw, output int ns);
    nw = 0;
    ns = 0;
    repeat (n) begin
      tick();
      nw += int'(upd_w);
      ns += int'(upd_s);
    end
  endtask

  task automatic press(input int idx, input int low_n, input int high_n,
                       output int nw, output int ns);
    int a, b, c, d;
    btn_n[idx] = 1'b0;
    run(low_n, a, b);
    btn_n[idx] = 1'b1;
    run(high_n, c, d);
    nw = a + c;
    ns = b + d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [18:0] exp_v;
    exp_v = '0;
    reset = 1'b0;
    btn_n = 3'b111;
    dec   = 1'b0;
    #2;
    checks++;
    if ({r_w, g_w, b_w} !== 24'h0 || {sel_w, upd_w} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: rgb=%h sel=%b upd=%b, want 0", {r_w, g_w, b_w}, sel_w, upd_w);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if ({r_w, g_w, b_w, sel_w, upd_w} !== {8'd0, exp_v} ||
          {r_s, g_s, b_s, sel_s, upd_s} !== {8'd0, exp_v}) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: w=%h s=%h, want 0", c,
                 {r_w, g_w, b_w, sel_w, upd_w}, {r_s, g_s, b_s, sel_s, upd_s});
      end
    end
  endtask

  task automatic test_hold_repeat();
    logic [7:0] er;
    logic [1:0] es;
    logic       eu;
    dec = 1'b0;
    btn_n[2] = 1'b0;
    for (int e = 1; e <= 52; e++) begin
      tick();
      if (e == 40) btn_n[2] = 1'b1;
      er = 8'd0;
      if (e >= 7)  er += 8'd8;
      if (e >= 27) er += 8'd8;
      if (e >= 32) er += 8'd8;
      if (e >= 37) er += 8'd8;
      if (e >= 42) er += 8'd8;
      eu = (e == 7 || e == 27 || e == 32 || e == 37 || e == 42);
      es = (e >= 7 && e < 47) ? 2'b01 : 2'b00;
      checks++;
      if ({r_w, sel_w, upd_w} !== {er, es, eu} || {r_s, sel_s, upd_s} !== {er, es, eu}) begin
        errors++;
        $display("FAIL hold_repeat edge%0d: w R=%0d sel=%b upd=%b s R=%0d sel=%b upd=%b, want R=%0d sel=%b upd=%b",
                 e, r_w, sel_w, upd_w, r_s, sel_s, upd_s, er, es, eu);
      end
    end
  endtask

  task automatic test_glitch();
    int nw, ns, tw, ts;
    tw = 0;
    ts = 0;
    for (int k = 0; k < 5; k++) begin
      press(1, 3, 5, nw, ns);
      tw += nw;
      ts += ns;
    end
    run(10, nw, ns);
    tw += nw;
    ts += ns;
    checks++;
    if (g_w !== 8'd0 || g_s !== 8'd0 || tw != 0 || ts != 0) begin
      errors++;
      $display("FAIL glitch: G w=%0d s=%0d upd w=%0d s=%0d, want 0", g_w, g_s, tw, ts);
    end
  endtask

  task automatic test_dec_underflow();
    int nw, ns;
    dec = 1'b1;
    press(0, 8, 12, nw, ns);
    dec = 1'b0;
    checks++;
    if (b_w !== 8'd248 || nw != 1) begin
      errors++;
      $display("FAIL dec_wrap: B=%0d upd=%0d, want 248 upd=1", b_w, nw);
    end
    checks++;
    if (b_s !== 8'd0 || ns != 1) begin
      errors++;
      $display("FAIL dec_sat: B=%0d upd=%0d, want 0 upd=1", b_s, ns);
    end
  endtask

  task automatic test_wrap();
    int nw, ns, tw, ts;
    do_reset();
    dec = 1'b0;
    tw = 0;
    ts = 0;
    for (int k = 0; k < 31; k++) begin
      press(0, 8, 12, nw, ns);
      tw += nw;
      ts += ns;
    end
    checks++;
    if (b_w !== 8'd248 || b_s !== 8'd248 || tw != 31 || ts != 31) begin
      errors++;
      $display("FAIL preset: B w=%0d s=%0d upd w=%0d s=%0d, want 248 and 31", b_w, b_s, tw, ts);
    end
    press(0, 8, 12, nw, ns);
    checks++;
    if (b_w !== 8'd0 || nw != 1) begin
      errors++;
      $display("FAIL wrap_over: B=%0d upd=%0d, want 0 upd=1", b_w, nw);
    end
    checks++;
    if (b_s !== 8'd255 || ns != 1) begin
      errors++;
      $display("FAIL sat_over: B=%0d upd=%0d, want 255 upd=1", b_s, ns);
    end
    press(0, 8, 12, nw, ns);
    checks++;
    if (b_s !== 8'd255 || ns != 1) begin
      errors++;
      $display("FAIL sat_hold: B=%0d upd=%0d, want 255 upd=1", b_s, ns);
    end
    checks++;
    if (b_w !== 8'd8 || nw != 1) begin
      errors++;
      $display("FAIL wrap_next: B=%0d upd=%0d, want 8 upd=1", b_w, nw);
    end
  endtask

  task automatic test_simultaneous();
    int nw, ns;
    do_reset();
    btn_n = 3'b001;
    run(10, nw, ns);
    checks++;
    if (r_w !== 8'd8 || g_w !== 8'd0 || sel_w !== 2'b01 || nw != 1 ||
        r_s !== 8'd8 || g_s !== 8'd0 || ns != 1) begin
      errors++;
      $display("FAIL simul_pick: R=%0d G=%0d sel=%b upd=%0d, want R=8 G=0 sel=01 upd=1",
               r_w, g_w, sel_w, nw);
    end
    btn_n = 3'b101;
    run(14, nw, ns);
    checks++;
    if (g_w !== 8'd0 || g_s !== 8'd0 || sel_w !== 2'b00 || nw != 0 || ns != 0) begin
      errors++;
      $display("FAIL simul_ignore: G=%0d sel=%b upd=%0d, want G=0 sel=00 upd=0", g_w, sel_w, nw);
    end
    btn_n = 3'b111;
    run(12, nw, ns);
    btn_n[1] = 1'b0;
    run(10, nw, ns);
    checks++;
    if (g_w !== 8'd8 || g_s !== 8'd8 || sel_w !== 2'b10 || r_w !== 8'd8 || nw != 1) begin
      errors++;
      $display("FAIL simul_repress: G=%0d R=%0d sel=%b upd=%0d, want G=8 R=8 sel=10 upd=1",
               g_w, r_w, sel_w, nw);
    end
    btn_n[1] = 1'b1;
    run(12, nw, ns);
  endtask

  task automatic test_reset_midrepeat();
    int nw, ns;
    do_reset();
    btn_n[2] = 1'b0;
    run(43, nw, ns);
    checks++;
    if (r_w !== 8'd40 || r_s !== 8'd40 || nw != 5) begin
      errors++;
      $display("FAIL pre_reset: R w=%0d s=%0d upd=%0d, want 40 and 5", r_w, r_s, nw);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (r_w !== 8'd0 || r_s !== 8'd0 || sel_w !== 2'b00 || upd_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_mid: R w=%0d s=%0d sel=%b upd=%b, want 0", r_w, r_s, sel_w, upd_w);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) begin
        checks++;
        if (r_w !== 8'd0 || upd_w !== 1'b0) begin
          errors++;
          $display("FAIL post_reset_e6: R=%0d upd=%b, want 0 0", r_w, upd_w);
        end
      end
      if (e == 7) begin
        checks++;
        if (r_w !== 8'd8 || r_s !== 8'd8 || upd_w !== 1'b1 || sel_w !== 2'b01) begin
          errors++;
          $display("FAIL post_reset_e7: R w=%0d s=%0d upd=%b sel=%b, want 8 8 1 01",
                   r_w, r_s, upd_w, sel_w);
        end
      end
    end
    btn_n = 3'b111;
    run(12, nw, ns);
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_glitch();
    test_dec_underflow();
    test_wrap();
    test_simultaneous();
    test_reset_midrepeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
